spram_nphase: RTL and testbench

SPRAM_NPHASE -- requirements
Module: spram_nphase

---
 rtl/spram_pkg.sv | 15 +
 rtl/spram_be.sv | 46 ++++
 rtl/spram_nphase.sv | 100 ++++++++++
 tb/tb_spram_nphase.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared constants and sizing helpers for the multi-phase single-port RAM.
package spram_pkg;

  localparam int BYTE_W = 8;

  // Width of an index that can address n items; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int nbytes(input int dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/spram_be.sv
// Single-port byte-enable RAM; the read address is registered and read data
// is a combinational lookup at that address.
module spram_be
  import spram_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DW-1:0]         di_i,
  input  logic [nbytes(DW)-1:0] be_i,
  output logic [DW-1:0]         rdata_o
);

  localparam int NB = nbytes(DW);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] raddr_q;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
    end else if (cs_i) begin
      raddr_q <= addr_i;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; resetting it
  // would prevent mapping onto a RAM macro and must not clear contents anyway.
  always_ff @(posedge clk) begin
    if (cs_i && we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) mem_q[addr_i][i*BYTE_W +: BYTE_W] <= di_i[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/spram_nphase.sv
// Time-shares one single-port RAM among NPH phases; each ph_en pulse hands
// ownership to a phase and captures the previous owner's read data.
module spram_nphase
  import spram_pkg::*;
#(
  parameter int AW  = 10,
  parameter int DW  = 32,
  parameter int NPH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NPH-1:0]            ph_en,
  input  logic [NPH-1:0]            ph_cs,
  input  logic [NPH-1:0]            ph_we,
  input  logic [NPH*AW-1:0]         ph_addr,
  input  logic [NPH*DW-1:0]         ph_di,
  input  logic [NPH*nbytes(DW)-1:0] ph_be,
  output logic [NPH*DW-1:0]         ph_do,
  output logic [NPH-1:0]            ph_vld,
  output logic                      err
);

  localparam int IW = idx_w(NPH);
  localparam int NB = nbytes(DW);

  logic [IW-1:0]     cur_q, cur_d;
  logic              own_vld_q, own_vld_d;
  logic [NPH*DW-1:0] ph_do_q, ph_do_d;
  logic [NPH-1:0]    ph_vld_q, ph_vld_d;
  logic              err_q, err_d;

  logic [IW-1:0] low_idx;
  logic          any_en;
  logic          multi_en;
  logic [DW-1:0] rdata;

  assign any_en   = |ph_en;
  assign multi_en = |(ph_en & (ph_en - NPH'(1)));

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    low_idx = '0;
    for (int k = NPH - 1; k >= 0; k--) begin
      if (ph_en[k]) low_idx = IW'(k);
    end
  end

  spram_be #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs_i    (ph_cs[cur_q]),
    .we_i    (ph_we[cur_q]),
    .addr_i  (ph_addr[int'(cur_q)*AW +: AW]),
    .di_i    (ph_di[int'(cur_q)*DW +: DW]),
    .be_i    (ph_be[int'(cur_q)*NB +: NB]),
    .rdata_o (rdata)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cur_d     = cur_q;
    own_vld_d = own_vld_q;
    ph_do_d   = ph_do_q;
    ph_vld_d  = '0;
    err_d     = err_q | multi_en;
    if (any_en) begin
      cur_d     = low_idx;
      own_vld_d = 1'b1;
      if (own_vld_q) begin
        ph_do_d[int'(cur_q)*DW +: DW] = rdata;
        ph_vld_d[cur_q]               = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q     <= '0;
      own_vld_q <= 1'b0;
      ph_do_q   <= '0;
      ph_vld_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      own_vld_q <= own_vld_d;
      ph_do_q   <= ph_do_d;
      ph_vld_q  <= ph_vld_d;
      err_q     <= err_d;
    end
  end

  assign ph_do  = ph_do_q;
  assign ph_vld = ph_vld_q;
  assign err    = err_q;

endmodule

// File: tb/tb_spram_nphase.sv
// Scoreboard bench for spram_nphase: each ownership hand-off pushes the
// expected capture; a negedge monitor pops and compares on every ph_vld.
module tb_spram_nphase;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int NPH = 4;

  typedef struct {
    int          slice;
    logic [31:0] data;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic [NPH-1:0]      ph_en, ph_cs, ph_we;
  logic [NPH*AW-1:0]   ph_addr;
  logic [NPH*DW-1:0]   ph_di;
  logic [NPH*DW/8-1:0] ph_be;
  logic [NPH*DW-1:0]   ph_do;
  logic [NPH-1:0]      ph_vld;
  logic                err;

  exp_t         sb_q[$];
  logic [127:0] model_do;
  int           n_checks;
  int           n_fail;

  spram_nphase #(.AW(AW), .DW(DW), .NPH(NPH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ph_en   (ph_en),
    .ph_cs   (ph_cs),
    .ph_we   (ph_we),
    .ph_addr (ph_addr),
    .ph_di   (ph_di),
    .ph_be   (ph_be),
    .ph_do   (ph_do),
    .ph_vld  (ph_vld),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && ph_vld != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_vld", {124'd0, ph_vld}, 128'd0);
      end else begin
        e = sb_q.pop_front();
        model_do[e.slice*32 +: 32] = e.data;
        check("vld_slot", {124'd0, ph_vld}, {124'd0, 4'b0001 << e.slice});
        check("ph_do_all", ph_do, model_do);
      end
    end
  end

  task automatic set_phase(input int k, input bit cs, input bit we, input logic [9:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    ph_cs[k]             = cs;
    ph_we[k]             = we;
    ph_addr[k*AW +: AW]  = a;
    ph_di[k*DW +: DW]    = d;
    ph_be[k*4 +: 4]      = be;
  endtask

  // Ownership hand-off with an expected capture, then three idle edges.
  task automatic select(input logic [3:0] mask, input int slice, input logic [31:0] data);
    exp_t e;
    e.slice = slice;
    e.data  = data;
    sb_q.push_back(e);
    @(posedge clk); #1 ph_en = mask;
    @(posedge clk); #1 ph_en = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // First hand-off after reset: nothing may be captured.
  task automatic first_pulse(input logic [3:0] mask);
    @(posedge clk); #1 ph_en = mask;
    @(posedge clk);
    @(negedge clk);
    check("first_en_no_vld", {124'd0, ph_vld}, 128'd0);
    ph_en = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_ph_do", ph_do, 128'd0);
    check("rst_ph_vld", {124'd0, ph_vld}, 128'd0);
    check("rst_err", {127'd0, err}, 128'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_do = '0;
    rst_n    = 1'b0;
    ph_en    = '0;
    ph_cs    = '0;
    ph_we    = '0;
    ph_addr  = '0;
    ph_di    = '0;
    ph_be    = '0;

    repeat (2) @(posedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;

    // Fill, read-after-write and byte-enable merge.
    set_phase(0, 1, 1, 10'h003, 32'hCAFEF00D, 4'b1111);
    first_pulse(4'b0001);
    set_phase(1, 1, 1, 10'h005, 32'hDEADBEEF, 4'b1111);
    select(4'b0010, 0, 32'hCAFEF00D);
    set_phase(2, 1, 0, 10'h005, 32'h0, 4'b0000);
    select(4'b0100, 1, 32'hDEADBEEF);
    set_phase(3, 1, 1, 10'h010, 32'h11223344, 4'b1111);
    select(4'b1000, 2, 32'hDEADBEEF);
    set_phase(0, 1, 1, 10'h010, 32'hAABBCCDD, 4'b0101);
    select(4'b0001, 3, 32'h11223344);
    set_phase(1, 1, 0, 10'h010, 32'h0, 4'b0000);
    select(4'b0010, 0, 32'h11BB33DD);
    set_phase(2, 1, 1, 10'h020, 32'h0BADC0DE, 4'b1111);
    select(4'b0100, 1, 32'h11BB33DD);

    // Round-robin reads over four distinct addresses.
    set_phase(3, 1, 0, 10'h003, 32'h0, 4'b0000);
    select(4'b1000, 2, 32'h0BADC0DE);
    set_phase(0, 1, 0, 10'h005, 32'h0, 4'b0000);
    select(4'b0001, 3, 32'hCAFEF00D);
    select(4'b0010, 0, 32'hDEADBEEF);
    set_phase(2, 1, 0, 10'h020, 32'h0, 4'b0000);
    select(4'b0100, 1, 32'h11BB33DD);
    select(4'b1000, 2, 32'h0BADC0DE);
    select(4'b0001, 3, 32'hCAFEF00D);

    // Same phase re-selected back-to-back.
    select(4'b0001, 0, 32'hDEADBEEF);

    // Two enables at once: lowest wins and err sticks.
    @(negedge clk);
    check("err_before", {127'd0, err}, 128'd0);
    set_phase(1, 1, 0, 10'h003, 32'h0, 4'b0000);
    set_phase(2, 0, 0, 10'h000, 32'h0, 4'b0000);
    select(4'b0110, 0, 32'hDEADBEEF);
    @(negedge clk);
    check("err_set", {127'd0, err}, 128'd1);
    select(4'b1000, 1, 32'hCAFEF00D);
    @(negedge clk);
    check("err_sticky", {127'd0, err}, 128'd1);

    // Reset with a capture pending; memory survives.
    @(posedge clk); #1 rst_n = 1'b0;
    model_do = '0;
    check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    set_phase(0, 1, 0, 10'h010, 32'h0, 4'b0000);
    first_pulse(4'b0001);
    set_phase(1, 1, 0, 10'h020, 32'h0, 4'b0000);
    select(4'b0010, 0, 32'h11BB33DD);
    select(4'b0001, 1, 32'h0BADC0DE);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_drain", 128'(sb_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
